// File: rtl/snake_disp_pkg.sv
// Shared constants and types for the score display: segment encodings, team codes,
// converter FSM states.
package snake_disp_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [1:0] TEAM1 = 2'd1;
    localparam logic [1:0] TEAM2 = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } conv_state_e;

    // Segment pattern for a BCD nibble; non-decimal codes blank the digit
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        if (d < 4'd10) begin
            return SEG_DIGIT[d];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD nibbles, one bit per cycle.
module bin2bcd_seq
    import snake_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] bin_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] hund_o,
    output logic [3:0] tens_o,
    output logic [3:0] unit_o
);

    conv_state_e state_q, state_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [11:0] adj;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  unit_q, unit_d;

    // Add 3 to every nibble >= 5 so the following shift carries correctly into the next digit
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter next-state: capture in idle, eight adjust+shift steps, then publish
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        unit_d  = unit_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d = 12'({adj, bin_q[7]});
                bin_d = {bin_q[6:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // All three digits change together so the display never mixes two values
                hund_d  = bcd_q[11:8];
                tens_d  = bcd_q[7:4];
                unit_d  = bcd_q[3:0];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Converter state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            unit_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            unit_q  <= unit_d;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);
    assign hund_o = hund_q;
    assign tens_o = tens_q;
    assign unit_o = unit_q;

endmodule

// File: rtl/seg7_score_display.sv
// Four-digit multiplexed score display: team numeral on the left, score (0-255) on the right,
// alternating between both final scores once the game is complete.
module seg7_score_display
    import snake_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 25000,
    parameter int unsigned ALT_DIV  = 200_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] score_i,
    input  logic [7:0] team1_score_i,
    input  logic [7:0] team2_score_i,
    input  logic [1:0] current_team_i,
    input  logic       game_complete_i,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    localparam int unsigned ScanW = $clog2(SCAN_DIV);
    localparam int unsigned AltW  = $clog2(ALT_DIV);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
    localparam logic [AltW-1:0]  AltLast  = AltW'(ALT_DIV - 1);

    logic [AltW-1:0]  alt_cnt_q, alt_cnt_d;
    logic             alt_sel_q, alt_sel_d;
    logic [7:0]       val_req_q, val_req_d;
    logic [1:0]       team_req_q, team_req_d;
    logic [7:0]       val_cap_q, val_shown_q;
    logic [1:0]       team_cap_q, team_shown_q;
    logic             first_q;
    logic             conv_start, conv_busy, conv_done;
    logic [3:0]       hund, tens, unit;
    logic [ScanW-1:0] slot_q;
    logic [1:0]       idx_q;
    logic             slot_wrap;
    logic [3:0]       an_q;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    // Source select and alternation timer; both held at team 1 while the game is live
    always_comb begin
        alt_cnt_d  = '0;
        alt_sel_d  = 1'b0;
        val_req_d  = score_i;
        team_req_d = current_team_i;
        if (game_complete_i) begin
            val_req_d  = alt_sel_q ? team2_score_i : team1_score_i;
            team_req_d = alt_sel_q ? TEAM2 : TEAM1;
            alt_sel_d  = alt_sel_q;
            alt_cnt_d  = alt_cnt_q + 1'b1;
            if (alt_cnt_q == AltLast) begin
                alt_cnt_d = '0;
                alt_sel_d = ~alt_sel_q;
            end
        end
    end

    // Request and alternation registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alt_cnt_q  <= '0;
            alt_sel_q  <= 1'b0;
            val_req_q  <= '0;
            team_req_q <= '0;
        end else begin
            alt_cnt_q  <= alt_cnt_d;
            alt_sel_q  <= alt_sel_d;
            val_req_q  <= val_req_d;
            team_req_q <= team_req_d;
        end
    end

    // Team is compared too, so a team change with an equal score still refreshes the numeral
    assign conv_start = first_q || (val_req_q != val_shown_q) || (team_req_q != team_shown_q);

    // Capture value+team together at start, publish them together when the converter is done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q      <= 1'b1;
            val_cap_q    <= '0;
            team_cap_q   <= '0;
            val_shown_q  <= '0;
            team_shown_q <= '0;
        end else begin
            if (conv_start && !conv_busy) begin
                first_q    <= 1'b0;
                val_cap_q  <= val_req_q;
                team_cap_q <= team_req_q;
            end
            if (conv_done) begin
                val_shown_q  <= val_cap_q;
                team_shown_q <= team_cap_q;
            end
        end
    end

    bin2bcd_seq u_bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(conv_start),
        .bin_i  (val_req_q),
        .busy_o (conv_busy),
        .done_o (conv_done),
        .hund_o (hund),
        .tens_o (tens),
        .unit_o (unit)
    );

    assign slot_wrap = (slot_q == ScanLast);

    // Pattern for the digit whose slot is starting, with leading-zero blanking
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        case (idx_q)
            2'd0: seg_d = seg_of(unit);
            2'd1: if (hund != 4'd0 || tens != 4'd0) seg_d = seg_of(tens);
            2'd2: if (hund != 4'd0) seg_d = seg_of(hund);
            2'd3: begin
                if (team_shown_q == TEAM1) begin
                    seg_d = SEG_DIGIT[1];
                    dp_d  = 1'b0;
                end else if (team_shown_q == TEAM2) begin
                    seg_d = SEG_DIGIT[2];
                    dp_d  = 1'b0;
                end else begin
                    seg_d = SEG_DASH;
                end
            end
            default: seg_d = SEG_BLANK;
        endcase
    end

    // Scan: pins load only at a slot wrap, so the first digit lights SCAN_DIV cycles after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            idx_q  <= '0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else if (slot_wrap) begin
            slot_q <= '0;
            idx_q  <= idx_q + 2'd1;
            an_q   <= ~(4'b0001 << idx_q);
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end else begin
            slot_q <= slot_q + 1'b1;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: doc/seg7_score_display.md
# seg7_score_display

Drives the board's 4-digit, common-anode seven-segment display with the snake game's score and team information. It sits downstream of the score and team bookkeeping in the top level and consumes `score`, `team1_score`, `team2_score`, `current_team` and `game_complete` alongside the VGA path. Binary scores are converted to BCD by a sequential double-dabble engine. The four digits are time-multiplexed at a fixed scan rate. After both teams finish, the display alternates between the two final scores.

## Interface
- `SCAN_DIV`, default 25000: clk cycles per digit slot (100 MHz gives a 4 kHz slot rate and a 1 kHz full refresh); must be ≥ 2.
- `ALT_DIV`, default 200_000_000: clk cycles each team's final score is shown while `game_complete`; must be ≥ 2.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `score` in 8: live score of the team currently playing, unsigned.
- `team1_score` in 8: saved team 1 score.
- `team2_score` in 8: saved team 2 score.
- `current_team` in 2: 1 = team 1, 2 = team 2; 0 and 3 are invalid.
- `game_complete` in 1: both teams have played; level.
- `an` out 4: digit enables, active-low; `an[3]` is the leftmost digit.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.

## Operation
- **Source select (combinational, registered into `val_req`):**
  - When `game_complete`=0, the value is `score` and the team digit is `current_team`.
  - When `game_complete`=1, the value is `team1_score` while `alt_sel`=0 and `team2_score` while `alt_sel`=1. The team digit is 1 or 2 accordingly.
- **Alternation timer:**
  - The counter runs only while `game_complete`=1. At `ALT_DIV`-1 it wraps to 0 and toggles `alt_sel`.
  - When `game_complete`=0, the counter and `alt_sel` are held at 0. Each completion therefore starts by showing team 1.
- **Converter FSM:** states IDLE, SHIFT, DONE.
  - IDLE: if `val_req` ≠ `val_shown`, or a conversion has never been done since reset, capture `val_req` into the shift register, clear the BCD register, set iteration count 0 and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift left one bit with the binary MSB entering. After 8 iterations go to DONE.
  - DONE: load `hund`/`tens`/`unit` and `val_shown`, then return to IDLE.
- **Consistency rule:** the team digit is latched together with the value at capture. Displayed digits never mix two source values.
- **Digit mapping:**
  - Digit 3 shows the team numeral with `dp` lit. An invalid team shows a dash (segment g only) with `dp` off.
  - Digit 2 shows hundreds, blanked when `hund`=0.
  - Digit 1 shows tens, blanked when both `hund` and `tens` are 0.
  - Digit 0 always shows units.
- **Scan:**
  - A slot counter counts 0 to `SCAN_DIV`-1. On wrap, the digit index advances 0→1→2→3→0.
  - `an`, `seg` and `dp` are registered from the index and digit registers. Exactly one `an` bit is low at any time after the first slot.
- **Arithmetic and widths:**
  - BCD nibbles are 4 bits each; `hund` ≤ 2.
  - Counter widths are `$clog2` of their divisor.
  - No saturation is needed, since all 8-bit values fit in 3 digits.

## Timing
- **Reset values:**
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1.
  - Digit index 0, counters 0, `alt_sel`=0.
  - `hund`=`tens`=`unit`=0, `val_shown`=0, FSM in IDLE with the first-conversion flag set.
- **Conversion latency:** an input change reaches `val_req` after 1 cycle. Capture happens 1 cycle later, followed by 8 SHIFT cycles, then DONE. Digit registers update 11 cycles after the input edge and appear on the pins at the next slot of the affected digit.
- **Change during SHIFT:** the conversion in progress completes with the captured value. A fresh conversion captures in the IDLE cycle immediately after DONE.
- **Simultaneous events:**
  - An alternation toggle and a digit-slot wrap on the same cycle are independent; both take effect.
  - Deasserting `game_complete` mid-conversion only affects the next capture.
- **Asynchronous reset mid-scan:** outputs blank immediately. The first `an` low appears `SCAN_DIV` cycles after release.

## Structure
- Package `snake_disp_pkg` holds:
  - segment encodings `SEG_DIGIT[0:9]`, `SEG_BLANK`=7'h7F, `SEG_DASH`=7'h3F;
  - team codes `TEAM1`=2'd1 and `TEAM2`=2'd2;
  - the FSM state typedef.
- Sub-module `bin2bcd_seq` holds the converter.
  - Ports: `clk`, `rst_n`, `start`, `bin[7:0]`, `busy`, `done` (1-cycle pulse), and the `hund`, `tens`, `unit` outputs.
  - The top of the block holds source select, alternation, digit registers and scan.

## Test plan
Use `SCAN_DIV`=4 and `ALT_DIV`=64.
- Reset, then `score`=0 with `current_team`=1 → the slot sequence shows `an`=1110 with seg "0"; digits 1 and 2 are `SEG_BLANK`; digit 3 shows "1" with `dp`=0.
- `score` 7→255 → digits show 2,5,5 exactly 11 cycles after the change; BCD is checked against a reference for all 256 values.
- `score` changes 3 cycles into SHIFT (12→99) → "12" is displayed first, then "99"; no mixed digits such as "92" ever appear.
- `game_complete`=1 with `team1_score`=40 and `team2_score`=133 → the display alternates team 1 "40" and team 2 "133" every 64 cycles, starting with team 1. Deasserting `game_complete` returns to the live score, and `alt_sel` is 0.
- `current_team`=3 → digit 3 shows `SEG_DASH` and `dp`=1.
- Assert `rst_n` low mid-scan → `an`=1111 and `seg`=7'h7F in the same cycle. After release, the scan resumes at digit 0 after 4 cycles.
